// File: rtl/dbus_seq_pkg.sv
// Shared definitions for the dbus transmit sequencer: FSM state codes
// (also exported on o_state) and small helpers used by the top and timer.
package dbus_seq_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned COUNT_W = 16;
  localparam int unsigned DATA_W  = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_XFER   = 3'd3,
    ST_GAP    = 3'd4,
    ST_ABORT  = 3'd5
  } seq_state_t;

  // States in which the dbus handshake is being watched for a timeout.
  function automatic logic timer_running(input seq_state_t s);
    return (s == ST_LAUNCH) || (s == ST_XFER);
  endfunction

endpackage

// File: rtl/dbus_seq_timer.sv
// Timeout counter for the dbus handshake: counts while enabled, restarts on
// clear, flags expire once the count reaches c_TIMEOUT-1.
module dbus_seq_timer #(
  parameter int unsigned c_TIMEOUT = 1000000,
  parameter int unsigned c_TWIDTH  = 20
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [c_TWIDTH-1:0] LIMIT = c_TWIDTH'(c_TIMEOUT - 1);

  logic [c_TWIDTH-1:0] count;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  always_comb begin
    expire = enable && (count == LIMIT);
  end

endmodule

// File: rtl/dbus_tx_sequencer.sv
// Byte sequencer from a level-handshake source onto dbus, with timeout abort
// and completed-byte counter. Inter-byte gap state enabled by DBUS_SEQ_GAP_EN.
module dbus_tx_sequencer
  import dbus_seq_pkg::*;
#(
  parameter int unsigned c_TIMEOUT = 1000000,
  parameter int unsigned c_GAP     = 16,
  parameter int unsigned c_TWIDTH  = 20
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_avail,
  input  logic [DATA_W-1:0]    i_data,
  output logic                 o_read,
  output logic [DATA_W-1:0]    o_data,
  output logic                 o_enable,
  input  logic                 i_busy,
  input  logic                 i_clear,
  output logic                 o_timeout,
  output logic [COUNT_W-1:0]   o_count,
  output logic [STATE_W-1:0]   o_state
);

  seq_state_t state;
  logic       timer_clear;
  logic       timer_en;
  logic       timer_expire;

`ifdef DBUS_SEQ_GAP_EN
  localparam int unsigned GAP_W = (c_GAP > 1) ? $clog2(c_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(c_GAP - 1);
  logic [GAP_W-1:0] gap_cnt;
`else
  // Gap length has no effect in this build; parameter kept for override compatibility.
  if (c_GAP != 0) begin : g_gap_compiled_out
  end
`endif

  // The timer restarts whenever the FSM is outside LAUNCH/XFER and on the
  // LAUNCH->XFER hand-over, so each of those states starts counting at zero.
  always_comb begin
    timer_en    = timer_running(state);
    timer_clear = !timer_en || ((state == ST_LAUNCH) && i_busy);
  end

  dbus_seq_timer #(
    .c_TIMEOUT (c_TIMEOUT),
    .c_TWIDTH  (c_TWIDTH)
  ) u_timer (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .clear     (timer_clear),
    .enable    (timer_en),
    .expire    (timer_expire)
  );

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state     <= ST_IDLE;
      o_read    <= 1'b0;
      o_enable  <= 1'b0;
      o_data    <= '0;
      o_timeout <= 1'b0;
      o_count   <= '0;
`ifdef DBUS_SEQ_GAP_EN
      gap_cnt   <= '0;
`endif
    end else begin
      // Clear first; a coincident timeout below wins for o_timeout, while a
      // coincident increment is suppressed so o_count stays zero.
      if (i_clear) begin
        o_count   <= '0;
        o_timeout <= 1'b0;
      end

      unique case (state)
        ST_IDLE: begin
          if (i_avail && !i_busy) begin
            o_data <= i_data;
            o_read <= 1'b1;
            state  <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          if (!i_avail) begin
            o_read   <= 1'b0;
            o_enable <= 1'b1;
            state    <= ST_LAUNCH;
          end
        end

        ST_LAUNCH: begin
          if (timer_expire) begin
            o_enable  <= 1'b0;
            o_timeout <= 1'b1;
            state     <= ST_ABORT;
          end else if (i_busy) begin
            o_enable <= 1'b0;
            state    <= ST_XFER;
          end
        end

        ST_XFER: begin
          if (timer_expire) begin
            o_timeout <= 1'b1;
            state     <= ST_ABORT;
          end else if (!i_busy) begin
            if (!i_clear) begin
              o_count <= o_count + 1'b1;
            end
`ifdef DBUS_SEQ_GAP_EN
            gap_cnt <= '0;
            state   <= (c_GAP == 0) ? ST_IDLE : ST_GAP;
`else
            state   <= ST_IDLE;
`endif
          end
        end

`ifdef DBUS_SEQ_GAP_EN
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
`endif

        ST_ABORT: begin
          if (!i_busy) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    o_state = state;
  end

endmodule

// File: tb/tb_dbus_tx_sequencer.sv
// Self-checking bench for dbus_tx_sequencer (c_TIMEOUT=100, c_GAP=16);
// honours DBUS_SEQ_GAP_EN when deciding how many gap cycles to expect.
module tb_dbus_tx_sequencer;

  localparam int unsigned TMO = 100;
  localparam int unsigned GAP = 16;
`ifdef DBUS_SEQ_GAP_EN
  localparam int GAPN = GAP;
`else
  localparam int GAPN = 0;
`endif

  logic        i_clock   = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_avail   = 1'b0;
  logic [7:0]  i_data    = '0;
  logic        i_busy    = 1'b0;
  logic        i_clear   = 1'b0;
  logic        o_read;
  logic [7:0]  o_data;
  logic        o_enable;
  logic        o_timeout;
  logic [15:0] o_count;
  logic [2:0]  o_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level expectations
  logic [15:0] exp_count   = '0;
  logic        exp_timeout = 1'b0;
  logic [7:0]  exp_data    = '0;
  bit          model_on    = 1'b0;

  int   cyc = 0;
  logic prev_read = 1'b0;
  int   read_rise[$];
  int   read_fall[$];

  always #5 i_clock = ~i_clock;

  dbus_tx_sequencer #(
    .c_TIMEOUT (TMO),
    .c_GAP     (GAP),
    .c_TWIDTH  (20)
  ) dut (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_avail   (i_avail),
    .i_data    (i_data),
    .o_read    (o_read),
    .o_data    (o_data),
    .o_enable  (o_enable),
    .i_busy    (i_busy),
    .i_clear   (i_clear),
    .o_timeout (o_timeout),
    .o_count   (o_count),
    .o_state   (o_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Model rules
  function automatic void model_reset();
    exp_count = '0; exp_timeout = 1'b0; exp_data = '0;
  endfunction
  function automatic void model_fetch(input logic [7:0] d);
    exp_data = d;
  endfunction
  function automatic void model_complete(input bit clr);
    exp_count = clr ? 16'h0000 : exp_count + 16'h0001;
    if (clr) exp_timeout = 1'b0;
  endfunction
  function automatic void model_timeout(input bit clr);
    exp_timeout = 1'b1;
    if (clr) exp_count = '0;
  endfunction
  function automatic void model_clear();
    exp_count = '0; exp_timeout = 1'b0;
  endfunction

  always @(posedge i_clock) cyc <= cyc + 1;

  // Per-cycle compare against the model
  always @(negedge i_clock) begin
    if (model_on) begin
      check("count", o_count, exp_count);
      check("timeout", o_timeout, exp_timeout);
      check("data", o_data, exp_data);
      check("read_enable_exclusive", o_read & o_enable, 0);
      if (o_read && !prev_read) read_rise.push_back(cyc);
      if (!o_read && prev_read) read_fall.push_back(cyc);
      prev_read = o_read;
    end
  end

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  // One complete byte; DUT must be idle with busy low on entry.
  task automatic send(input logic [7:0] d, input int dly, input int blen, input bit clr,
                      input bit nxt_avail, input logic [7:0] nxt);
    i_avail = 1'b1; i_data = d;
    tick(); model_fetch(d);
    check("fetch_state", o_state, 1);
    check("read_high", o_read, 1);
    i_avail = 1'b0; i_data = ~d;
    tick();
    check("launch_state", o_state, 2);
    check("enable_high", o_enable, 1);
    check("read_low", o_read, 0);
    repeat (dly) tick();
    check("enable_held", o_enable, 1);
    i_busy = 1'b1;
    tick();
    check("xfer_state", o_state, 3);
    check("enable_dropped", o_enable, 0);
    repeat (blen - 1) tick();
    i_busy = 1'b0; i_clear = clr;
    tick(); model_complete(clr);
    i_clear = 1'b0;
    if (nxt_avail) begin
      i_avail = 1'b1; i_data = nxt;
    end
    for (int g = 0; g < GAPN; g++) begin
      check("gap_state", o_state, 4);
      check("gap_no_read", o_read, 0);
      tick();
    end
    check("idle_after_gap", o_state, 0);
  endtask

  // Byte whose dbus never goes busy; optional clear on the expiring cycle.
  task automatic timeout_run(input logic [7:0] d, input bit clr);
    i_avail = 1'b1; i_data = d;
    tick(); model_fetch(d);
    i_avail = 1'b0;
    tick();
    for (int k = 1; k <= int'(TMO); k++) begin
      check("enable_until_timeout", o_enable, 1);
      if (k == int'(TMO)) i_clear = clr;
      tick();
    end
    i_clear = 1'b0; model_timeout(clr);
    check("timeout_enable_low", o_enable, 0);
    check("abort_state", o_state, 5);
    check("timeout_set", o_timeout, 1);
    tick();
    check("abort_to_idle", o_state, 0);
    repeat (3) begin
      tick();
      check("no_retry_state", o_state, 0);
      check("no_retry_read", o_read, 0);
    end
  endtask

  initial begin
    int rb, fb;

    repeat (3) tick();
    check("rst_read", o_read, 0);
    check("rst_enable", o_enable, 0);
    check("rst_data", o_data, 0);
    check("rst_timeout", o_timeout, 0);
    check("rst_count", o_count, 0);
    check("rst_state", o_state, 0);
    model_reset();
    model_on = 1'b1;
    i_reset_n = 1'b1;
    tick();

    // Single byte 0xA5, busy 3 cycles after enable, 40 cycles long
    send(8'hA5, 3, 40, 1'b0, 1'b0, 8'h00);
    check("single_data", o_data, 8'hA5);
    check("single_count", o_count, 1);
    check("single_timeout", o_timeout, 0);

    i_clear = 1'b1; tick(); model_clear(); i_clear = 1'b0;
    check("clear_count", o_count, 0);

    // Three back-to-back bytes with the source keeping i_avail up
    rb = read_rise.size(); fb = read_fall.size();
    send(8'h01, 0, 5, 1'b0, 1'b1, 8'h02);
    send(8'h02, 0, 5, 1'b0, 1'b1, 8'h03);
    send(8'h03, 0, 5, 1'b0, 1'b0, 8'h00);
    tick();
    check("b2b_count", o_count, 3);
    check("b2b_last_data", o_data, 8'h03);
    check("b2b_read_pulses", read_rise.size() - rb, 3);
    if (read_rise.size() - rb == 3 && read_fall.size() - fb == 3) begin
      for (int i = 0; i < 3; i++)
        check("b2b_read_width", read_fall[fb + i] - read_rise[rb + i], 1);
      for (int i = 1; i < 3; i++)
        check("b2b_read_spacing", read_rise[rb + i] - read_fall[fb + i - 1], 2 + 5 + GAPN);
    end

    // Source withdraws while dbus is busy in IDLE: no read issued
    i_busy = 1'b1; i_avail = 1'b1; i_data = 8'h77;
    repeat (3) begin
      tick();
      check("blocked_state", o_state, 0);
      check("blocked_read", o_read, 0);
    end
    i_avail = 1'b0; i_busy = 1'b0;
    repeat (2) begin
      tick();
      check("withdrawn_state", o_state, 0);
    end

    // Timeout with busy never rising
    timeout_run(8'hC3, 1'b0);
    check("tmo_count", o_count, 3);
    check("tmo_data_kept", o_data, 8'hC3);

    i_clear = 1'b1; tick(); model_clear(); i_clear = 1'b0;
    check("clear_timeout", o_timeout, 0);

    // Clear coinciding with timeout: flag wins, counter clears
    send(8'h11, 1, 4, 1'b0, 1'b0, 8'h00);
    timeout_run(8'h22, 1'b1);
    check("clr_tmo_timeout", o_timeout, 1);
    check("clr_tmo_count", o_count, 0);

    // Clear coinciding with XFER completion
    send(8'h3C, 2, 6, 1'b0, 1'b0, 8'h00);
    check("pre_clr_count", o_count, 1);
    send(8'h4D, 2, 6, 1'b1, 1'b0, 8'h00);
    check("clr_xfer_count", o_count, 0);
    check("clr_xfer_timeout", o_timeout, 0);

    // Counter wrap from 0xFFFF
    force dut.o_count = 16'hFFFF;
    #1;
    release dut.o_count;
    exp_count = 16'hFFFF;
    tick();
    check("preload_count", o_count, 16'hFFFF);
    send(8'h96, 1, 3, 1'b0, 1'b0, 8'h00);
    check("wrap_count", o_count, 0);

    // Reset in the middle of XFER
    send(8'h69, 0, 2, 1'b0, 1'b0, 8'h00);
    i_avail = 1'b1; i_data = 8'h5A;
    tick(); model_fetch(8'h5A);
    i_avail = 1'b0;
    tick();
    i_busy = 1'b1;
    tick();
    check("pre_reset_xfer", o_state, 3);
    repeat (4) tick();
    i_reset_n = 1'b0;
    tick(); model_reset();
    check("mid_rst_read", o_read, 0);
    check("mid_rst_enable", o_enable, 0);
    check("mid_rst_data", o_data, 0);
    check("mid_rst_timeout", o_timeout, 0);
    check("mid_rst_count", o_count, 0);
    check("mid_rst_state", o_state, 0);
    i_reset_n = 1'b1; i_busy = 1'b0;
    tick();
    check("post_rst_state", o_state, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
